rls_update_seq: RTL and testbench
=================================

// Module: rls_update_seq
// PURPOSE
//  Sequential RLS coefficient-update engine: x = x0 + k*(b - a'x0), signed fixed point.
//  Computes the a'x0 dot product and the k*e update with COMBSIZE multiplier lanes
//  time-shared over SIZE/COMBSIZE cycles, bracketed by a valid/ready handshake.
//  Sits after the gain (k) computation in the RLS datapath; feeds x back as next x0.
//  Adds a prior-error output, configurable Q-format, optional saturation, handshake.
// PARAMETERS
//  WIDTH     32  element width, signed two's complement
//  FRAC      16  fractional bits (Q(WIDTH-FRAC).FRAC)
//  SIZE      16  vector length; must be a multiple of COMBSIZE
//  COMBSIZE   4  multiplier lanes, i.e. elements processed per cycle
//  SATURATE   1  1: saturate e and x to the WIDTH range; 0: wrap
// PORTS
//  clk        in   1            single clock, rising edge
//  reset      in   1            synchronous, active-high
//  in_valid   in   1            x0/k/a/b valid
//  in_ready   out  1            engine idle, can accept
//  x0         in   WIDTH*SIZE   prior coefficients, element i at [WIDTH*i+:WIDTH]
//  k          in   WIDTH*SIZE   gain vector, same packing
//  a          in   WIDTH*SIZE   regressor vector, same packing
//  b          in   WIDTH        desired sample
//  out_valid  out  1            x/e valid, held until out_ready
//  out_ready  in   1            downstream accepts
//  x          out  WIDTH*SIZE   updated coefficients
//  e          out  WIDTH        prior error b - a'x0
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1, out_valid=0, x=0, e=0, accumulator and chunk counter 0.
//  - Reset is honoured in any state; an operation in flight is discarded, no output.
//  - FSM: IDLE -> DOT -> ERR -> UPD -> DONE -> IDLE. NCHUNK = SIZE/COMBSIZE.
//    IDLE: in_valid&in_ready registers x0,k,a,b; -> DOT, in_ready drops next cycle.
//    DOT : NCHUNK cycles; chunk c adds sum of (a[j]*x0[j])>>>FRAC over lanes j of chunk c.
//    ERR : 1 cycle; e_reg = b - acc (saturated/wrapped to WIDTH).
//    UPD : NCHUNK cycles; x[j] = x0[j] + ((k[j]*e_reg)>>>FRAC), COMBSIZE elements/cycle.
//    DONE: out_valid=1, x/e stable; out_ready -> IDLE (in_ready=1 next cycle).
//  - Latency: out_valid rises 2*NCHUNK+2 cycles after the accepting edge (10 at defaults).
//  - in_ready=1 only in IDLE; in_valid in other states is ignored, inputs not sampled.
//  - out_valid&out_ready on the first DONE cycle: one-cycle pulse; no back-to-back bypass.
//  - Arithmetic: products 2*WIDTH signed, arithmetic shift right by FRAC (truncate
//    toward -inf). Accumulator WIDTH+clog2(SIZE) bits, never saturates internally;
//    only e and each x[j] are narrowed to WIDTH (saturate if SATURATE=1, else wrap).
//  - x and e retain their last values in IDLE; overwritten only in ERR/UPD.
//  - Chunk counter wraps to 0 on DOT->ERR and UPD->DONE.
// STRUCTURE
//  - Shared include rls_defs.vh: default WIDTH/FRAC, state encodings, and a
//    sat_narrow function (wide signed -> WIDTH with saturate/wrap select).
//  - One sub-module, fxp_mul: signed WIDTH x WIDTH multiply, >>>FRAC, wide result;
//    COMBSIZE instances shared between DOT (a*x0) and UPD (k*e) via operand muxes.
//  - Top: FSM, chunk counter, input registers, accumulator, output registers.
// TESTING
//  1 Reset mid-DOT (cycle 2 after accept) -> out_valid stays 0, in_ready=1 after reset, x=0.
//  2 x0[i]=0.1i, a[i]=i, k[i]=i, b=15 (Q16.16) -> e=-109.0, x[i]=-108.9i
//    (x[15]=-1633.5), each within +/-16 LSB; out_valid exactly 10 cycles after accept.
//  3 All-zero a, x0=1.0, k=2.0, b=-3.0 -> e=-3.0 (0xFFFD0000), x[i]=-5.0.
//  4 a[i]=x0[i]=100.0, b=0, SATURATE=1 -> e=0x80000000, accumulator not clipped;
//    SATURATE=0 -> e = wrapped 32-bit value of -160000.0.
//  5 out_ready held low 20 cycles in DONE -> out_valid, x, e stable; in_valid pulses
//    ignored, in_ready=0 throughout.
//  6 Two transactions, out_ready=1 always -> second accepted the cycle after DONE, results
//    independent; repeat with SIZE=8, COMBSIZE=2 (latency 10) and COMBSIZE=SIZE (latency 4).

Source files
------------

// File: rtl/rls_update_seq_pkg.sv
// Shared state encoding, default Q-format and narrowing helper for the RLS update engine.
package rls_update_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOT,
    S_ERR,
    S_UPD,
    S_DONE
  } state_t;

  // Clamp to the signed w-bit range when sat is set; otherwise the caller's truncation wraps.
  function automatic logic signed [127:0] sat_narrow(input logic signed [127:0] v,
                                                     input int w, input bit sat);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/rls_update_seq_fxp_mul.sv
// Signed fixed-point multiplier lane: full-width product shifted right by FRAC (floor).
module fxp_mul
  import rls_update_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;

  assign full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign p    = full >>> FRAC;

endmodule

// File: rtl/rls_update_seq.sv
// Sequential RLS coefficient update x = x0 + k*(b - a'x0) on COMBSIZE shared multiplier lanes.
module rls_update_seq
  import rls_update_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int SIZE     = 16,
  parameter int COMBSIZE = 4,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*SIZE-1:0]   x0,
  input  logic [WIDTH*SIZE-1:0]   k,
  input  logic [WIDTH*SIZE-1:0]   a,
  input  logic [WIDTH-1:0]        b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*SIZE-1:0]   x,
  output logic [WIDTH-1:0]        e
);

  localparam int NCHUNK = SIZE / COMBSIZE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ACCW   = WIDTH + $clog2(SIZE);
  localparam int PW     = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [ACCW-1:0]  acc;
  logic signed [WIDTH-1:0] b_r;
  logic signed [WIDTH-1:0] e_reg;
  logic signed [WIDTH-1:0] x0_r [NCHUNK][COMBSIZE];
  logic signed [WIDTH-1:0] k_r  [NCHUNK][COMBSIZE];
  logic signed [WIDTH-1:0] a_r  [NCHUNK][COMBSIZE];
  logic signed [WIDTH-1:0] x_r  [NCHUNK][COMBSIZE];

  logic signed [WIDTH-1:0] op_l [COMBSIZE];
  logic signed [WIDTH-1:0] op_r [COMBSIZE];
  logic signed [PW-1:0]    prod [COMBSIZE];
  logic signed [WIDTH-1:0] upd  [COMBSIZE];
  logic signed [ACCW-1:0]  dot_sum;
  logic signed [WIDTH-1:0] err_n;

  // The lanes compute a*x0 during DOT and k*e during UPD on the current chunk.
  for (genvar l = 0; l < COMBSIZE; l++) begin : g_lane
    assign op_l[l] = (state == S_UPD) ? k_r[cnt][l] : a_r[cnt][l];
    assign op_r[l] = (state == S_UPD) ? e_reg       : x0_r[cnt][l];

    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
      .a(op_l[l]),
      .b(op_r[l]),
      .p(prod[l])
    );

    assign upd[l] = WIDTH'(sat_narrow(128'((PW+1)'(x0_r[cnt][l]) + (PW+1)'(prod[l])),
                                      WIDTH, SATURATE != 0));
  end

  always_comb begin
    dot_sum = '0;
    for (int l = 0; l < COMBSIZE; l++) dot_sum = dot_sum + ACCW'(prod[l]);
  end

  assign err_n = WIDTH'(sat_narrow(128'((ACCW+1)'(b_r) - (ACCW+1)'(acc)), WIDTH, SATURATE != 0));

  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && in_valid && in_ready) begin
      b_r <= b;
      for (int c = 0; c < NCHUNK; c++) begin
        for (int l = 0; l < COMBSIZE; l++) begin
          x0_r[c][l] <= x0[WIDTH*(c*COMBSIZE+l) +: WIDTH];
          k_r[c][l]  <= k[WIDTH*(c*COMBSIZE+l) +: WIDTH];
          a_r[c][l]  <= a[WIDTH*(c*COMBSIZE+l) +: WIDTH];
        end
      end
    end
  end

  // out_valid is registered one cycle into DONE and held until the downstream handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      e_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int c = 0; c < NCHUNK; c++)
        for (int l = 0; l < COMBSIZE; l++) x_r[c][l] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_DOT;
          end
        end
        S_DOT: begin
          acc <= acc + dot_sum;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ERR: begin
          e_reg <= err_n;
          state <= S_UPD;
        end
        S_UPD: begin
          for (int l = 0; l < COMBSIZE; l++) x_r[cnt][l] <= upd[l];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCHUNK; c++) begin : g_xc
    for (genvar l = 0; l < COMBSIZE; l++) begin : g_xl
      assign x[WIDTH*(c*COMBSIZE+l) +: WIDTH] = x_r[c][l];
    end
  end

  assign e = e_reg;

endmodule

// File: tb/tb_rls_update_seq.sv
// Directed bench for rls_update_seq: default, wrapping, SIZE=8/COMBSIZE=2 and COMBSIZE=SIZE builds.
module tb_rls_update_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   iv;
  logic [3:0]   ordy;
  logic [511:0] x0_v, k_v, a_v;
  logic [31:0]  b_v;

  logic         rdy0, rdy1, rdy2, rdy3;
  logic         ov0, ov1, ov2, ov3;
  logic [31:0]  e0, e1, e2, e3;
  logic [511:0] xo0, xo1, xo3;
  logic [255:0] xo2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    logic [31:0] av, x0v, kv, bv;
    logic [31:0] exp_e, exp_x;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  rls_update_seq #(.SATURATE(1)) d0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy0),
    .x0(x0_v), .k(k_v), .a(a_v), .b(b_v),
    .out_valid(ov0), .out_ready(ordy[0]), .x(xo0), .e(e0));

  rls_update_seq #(.SATURATE(0)) d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy1),
    .x0(x0_v), .k(k_v), .a(a_v), .b(b_v),
    .out_valid(ov1), .out_ready(ordy[1]), .x(xo1), .e(e1));

  rls_update_seq #(.SIZE(8), .COMBSIZE(2)) d2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy2),
    .x0(x0_v[255:0]), .k(k_v[255:0]), .a(a_v[255:0]), .b(b_v),
    .out_valid(ov2), .out_ready(ordy[2]), .x(xo2), .e(e2));

  rls_update_seq #(.SIZE(16), .COMBSIZE(16)) d3 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(rdy3),
    .x0(x0_v), .k(k_v), .a(a_v), .b(b_v),
    .out_valid(ov3), .out_ready(ordy[3]), .x(xo3), .e(e3));

  function automatic logic get_rdy(input int inst);
    case (inst)
      0: return rdy0;
      1: return rdy1;
      2: return rdy2;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic get_ov(input int inst);
    case (inst)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic [31:0] get_e(input int inst);
    case (inst)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return e3;
    endcase
  endfunction

  function automatic logic [511:0] get_x(input int inst);
    case (inst)
      0: return xo0;
      1: return xo1;
      2: return {256'b0, xo2};
      default: return xo3;
    endcase
  endfunction

  function automatic int size_of(input int inst);
    return (inst == 2) ? 8 : 16;
  endfunction

  function automatic logic [511:0] replicate(input logic [31:0] v, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic longint el(input logic [511:0] v, input int i);
    return longint'($signed(v[32*i +: 32]));
  endfunction

  function automatic logic [31:0] narrow(input longint v, input bit sat);
    longint t;
    t = v;
    if (sat && (t > 64'sd2147483647)) t = 64'sd2147483647;
    if (sat && (t < -64'sd2147483648)) t = -64'sd2147483648;
    return t[31:0];
  endfunction

  // Reference arithmetic on the currently driven input vectors.
  function automatic void model(input int n, input bit sat,
                                output logic [31:0] me, output logic [511:0] mx);
    longint acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc += (el(a_v, i) * el(x0_v, i)) >>> 16;
    me = narrow(longint'($signed(b_v)) - acc, sat);
    mx = '0;
    for (int i = 0; i < n; i++)
      mx[32*i +: 32] = narrow(el(x0_v, i) + ((el(k_v, i) * longint'($signed(me))) >>> 16), sat);
  endfunction

  task automatic load_uniform(input logic [31:0] av, input logic [31:0] x0v,
                              input logic [31:0] kv, input logic [31:0] bv);
    for (int i = 0; i < 16; i++) begin
      a_v[32*i +: 32]  = av;
      x0_v[32*i +: 32] = x0v;
      k_v[32*i +: 32]  = kv;
    end
    b_v = bv;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      x0_v[32*i +: 32] = (65536 * i + 5) / 10;
      a_v[32*i +: 32]  = i << 16;
      k_v[32*i +: 32]  = i << 16;
    end
    b_v = 15 << 16;
  endtask

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input int exp, input int tol);
    int diff;
    diff = $signed(act) - exp;
    total++;
    if ((diff > tol) || (diff < -tol)) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d +/- %0d", name, $signed(act), exp, tol);
    end
  endtask

  // One transaction: accept, count cycles to out_valid, capture, handshake.
  task automatic apply_stimulus(input int inst, output int lat,
                                output logic [31:0] eo, output logic [511:0] xo);
    int guard;
    @(negedge clk);
    iv[inst]   = 1'b1;
    ordy[inst] = 1'b0;
    guard = 0;
    while (!get_rdy(inst) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    iv[inst] = 1'b0;
    lat = 0;
    while (!get_ov(inst) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    eo = get_e(inst);
    xo = get_x(inst);
    ordy[inst] = 1'b1;
    @(negedge clk);
    ordy[inst] = 1'b0;
  endtask

  task automatic back_to_back(input int inst, input int exp_lat);
    logic [31:0]  me1, me2, ea, eb;
    logic [511:0] mx1, mx2, xa, xb;
    int c1, gap, g;
    load_ramp();
    model(size_of(inst), 1'b1, me1, mx1);
    @(negedge clk);
    iv[inst]   = 1'b1;
    ordy[inst] = 1'b1;
    g = 0;
    while (!get_rdy(inst) && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    load_uniform(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h000A_0000);
    model(size_of(inst), 1'b1, me2, mx2);
    c1 = 0;
    while (!get_ov(inst) && c1 < 200) begin
      @(negedge clk);
      c1++;
    end
    ea = get_e(inst);
    xa = get_x(inst);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!get_ov(inst) && gap < 200);
    eb = get_e(inst);
    xb = get_x(inst);
    iv[inst] = 1'b0;
    @(negedge clk);
    ordy[inst] = 1'b0;
    check_output($sformatf("b2b%0d_lat1", inst), c1, exp_lat);
    check_output($sformatf("b2b%0d_gap", inst), gap, exp_lat + 2);
    check_output($sformatf("b2b%0d_e1", inst), ea, me1);
    check_output($sformatf("b2b%0d_x1", inst), xa, mx1);
    check_output($sformatf("b2b%0d_e2", inst), eb, me2);
    check_output($sformatf("b2b%0d_x2", inst), xb, mx2);
  endtask

  initial begin
    int           lat;
    logic [31:0]  eo, me, eh;
    logic [511:0] xo, mx, xh;
    int           n_ov, n_e, n_x, n_rdy, g;

    tbl[0] = '{0, 32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'hFFFD_0000, 32'hFFFB_0000, 10};
    tbl[1] = '{0, 32'h0064_0000, 32'h0064_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0064_0000, 10};
    tbl[2] = '{1, 32'h0064_0000, 32'h0064_0000, 32'h0000_0000, 32'h0000_0000, 32'h8F00_0000, 32'h0064_0000, 10};
    tbl[3] = '{0, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h000A_0000, 32'h0002_0000, 32'h0001_0000, 10};
    tbl[4] = '{0, 32'h0000_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0064_0000, 32'h0064_0000, 32'h7FFF_FFFF, 10};
    tbl[5] = '{1, 32'h0000_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0064_0000, 32'h0064_0000, 32'h8063_0000, 10};
    tbl[6] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0011, 10};
    tbl[7] = '{2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFF8_0000, 32'hFFF9_0000, 10};
    tbl[8] = '{3, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h000A_0000, 32'h0002_0000, 32'h0001_0000, 4};

    reset = 1'b1;
    iv    = '0;
    ordy  = '0;
    load_uniform('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_in_ready", rdy0, 1'b1);
    check_output("reset_out_valid", ov0, 1'b0);
    check_output("reset_e", e0, 32'h0);
    check_output("reset_x", xo0, '0);

    for (int i = 0; i < 9; i++) begin
      load_uniform(tbl[i].av, tbl[i].x0v, tbl[i].kv, tbl[i].bv);
      apply_stimulus(tbl[i].inst, lat, eo, xo);
      check_output($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check_output($sformatf("vec%0d_e", i), eo, tbl[i].exp_e);
      check_output($sformatf("vec%0d_x", i), xo, replicate(tbl[i].exp_x, size_of(tbl[i].inst)));
      check_output($sformatf("vec%0d_ov_drop", i), get_ov(tbl[i].inst), 1'b0);
    end

    // Ramp: e near -109.0, x[i] near -108.9*i.
    load_ramp();
    model(16, 1'b1, me, mx);
    apply_stimulus(0, lat, eo, xo);
    check_output("ramp_lat", lat, 10);
    check_output("ramp_e", eo, me);
    check_output("ramp_x", xo, mx);
    check_tol("ramp_e_real", eo, -7143424, 16);
    check_tol("ramp_x1_real", xo[63:32], -7136870, 16);

    // Output held while out_ready is low; in_valid pulses must be ignored.
    load_uniform(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h000A_0000);
    @(negedge clk);
    iv[0] = 1'b1;
    g = 0;
    while (!rdy0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    g = 0;
    while (!ov0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    eh = e0;
    xh = xo0;
    n_ov = 0; n_e = 0; n_x = 0; n_rdy = 0;
    for (int c = 0; c < 20; c++) begin
      iv[0] = c[0];
      x0_v[31:0] = $urandom;
      b_v = $urandom;
      @(negedge clk);
      if (ov0 !== 1'b1) n_ov++;
      if (e0 !== eh) n_e++;
      if (xo0 !== xh) n_x++;
      if (rdy0 !== 1'b0) n_rdy++;
    end
    iv[0] = 1'b0;
    check_output("hold_e_value", eh, 32'h0002_0000);
    check_output("hold_ov_cycles_low", n_ov, 0);
    check_output("hold_e_changes", n_e, 0);
    check_output("hold_x_changes", n_x, 0);
    check_output("hold_in_ready_high", n_rdy, 0);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    check_output("hold_release_ov", ov0, 1'b0);
    check_output("hold_release_rdy", rdy0, 1'b1);
    @(negedge clk);
    check_output("idle_x_retained", xo0, xh);
    check_output("idle_ov_stays_low", ov0, 1'b0);

    back_to_back(0, 10);
    back_to_back(2, 10);
    back_to_back(3, 4);

    // Reset two cycles into DOT discards the operation.
    load_uniform(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h000A_0000);
    @(negedge clk);
    iv[0] = 1'b1;
    g = 0;
    while (!rdy0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_ov = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ov0 !== 1'b0) n_ov++;
    end
    check_output("rst_dot_no_output", n_ov, 0);
    check_output("rst_dot_in_ready", rdy0, 1'b1);
    check_output("rst_dot_x", xo0, '0);
    check_output("rst_dot_e", e0, 32'h0);
    apply_stimulus(0, lat, eo, xo);
    check_output("post_rst_e", eo, 32'h0002_0000);
    check_output("post_rst_lat", lat, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
